// File: rtl/exe_div.sv
// Multi-cycle radix-2 restoring divider for the EXE stage (MIPS DIV/DIVU).
// It stalls the pipeline while it runs and returns the quotient on lo and the remainder on hi.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a divide request; latches operands on accept
// BUSY    | one quotient bit per cycle, 32 iterations
// DIVZERO | divisor was zero; loads lo = all-ones and hi = dividend
// DONE    | result valid on hi/lo, ready pulses, pipeline released
module exe_div (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        exe_i_div_start,
  input  logic        exe_i_div_signed,
  input  logic [31:0] exe_i_src1,
  input  logic [31:0] exe_i_src2,
  input  logic        exe_i_annul,
  output logic        exe_o_stallreq,
  output logic        exe_o_div_ready,
  output logic [31:0] exe_o_div_hi,
  output logic [31:0] exe_o_div_lo
);

  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, BUSY, DIVZERO, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  cnt;
  word_t       rem;
  word_t       dvd;
  word_t       dsr;
  logic        neg_q;
  logic        neg_r;

  logic        accept;
  logic        src2_zero;
  logic        last_iter;
  word_t       src1_mag;
  word_t       src2_mag;
  logic [32:0] rem_shift;
  word_t       rem_sub;
  logic        q_bit;
  word_t       rem_next;
  word_t       quo_next;

  assign accept    = exe_i_div_start & ~exe_i_annul;
  assign src2_zero = (exe_i_src2 == 32'd0);
  assign last_iter = (cnt == 5'd31);

  // Magnitudes are unsigned, so -2^31 maps onto itself as 32'h8000_0000.
  assign src1_mag = (exe_i_div_signed & exe_i_src1[31]) ? (~exe_i_src1 + 32'd1) : exe_i_src1;
  assign src2_mag = (exe_i_div_signed & exe_i_src2[31]) ? (~exe_i_src2 + 32'd1) : exe_i_src2;

  // The shifted remainder needs 33 bits; after a successful subtract it fits in 32 again.
  assign rem_shift = {rem, dvd[31]};
  assign q_bit     = (rem_shift >= {1'b0, dsr});
  assign rem_sub   = rem_shift[31:0] - dsr;
  assign rem_next  = q_bit ? rem_sub : rem_shift[31:0];
  assign quo_next  = {dvd[30:0], q_bit};

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = src2_zero ? DIVZERO : BUSY;
        end
      end
      BUSY: begin
        if (exe_i_annul) begin
          state_nxt = IDLE;
        end else if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DIVZERO: begin
        state_nxt = exe_i_annul ? IDLE : DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Start is ignored while reset is held, so no stall is requested then.
  always_comb begin
    exe_o_stallreq  = 1'b0;
    exe_o_div_ready = 1'b0;
    case (state)
      IDLE:    exe_o_stallreq = accept & ~cpu_rst;
      BUSY:    exe_o_stallreq = ~exe_i_annul & ~cpu_rst;
      DIVZERO: exe_o_stallreq = ~exe_i_annul & ~cpu_rst;
      DONE:    exe_o_div_ready = 1'b1;
      default: exe_o_stallreq = 1'b0;
    endcase
  end

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      cnt          <= 5'd0;
      rem          <= 32'd0;
      dvd          <= 32'd0;
      dsr          <= 32'd0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      exe_o_div_hi <= 32'd0;
      exe_o_div_lo <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !src2_zero) begin
            dvd   <= src1_mag;
            dsr   <= src2_mag;
            rem   <= 32'd0;
            cnt   <= 5'd0;
            neg_q <= exe_i_div_signed & (exe_i_src1[31] ^ exe_i_src2[31]);
            neg_r <= exe_i_div_signed & exe_i_src1[31];
          end
        end
        BUSY: begin
          if (!exe_i_annul) begin
            rem <= rem_next;
            dvd <= quo_next;
            cnt <= cnt + 5'd1;
            if (last_iter) begin
              exe_o_div_lo <= neg_q ? (~quo_next + 32'd1) : quo_next;
              exe_o_div_hi <= neg_r ? (~rem_next + 32'd1) : rem_next;
            end
          end
        end
        DIVZERO: begin
          // The stalled ID/EXE register still presents the dividend here.
          if (!exe_i_annul) begin
            exe_o_div_lo <= 32'hFFFF_FFFF;
            exe_o_div_hi <= exe_i_src1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exe_div.sv
// Directed testbench for exe_div: timing of stall/ready, signed and unsigned results,
// divide-by-zero, annul and asynchronous reset in the middle of a division.
module tb_exe_div;

  logic        cpu_clk_50M;
  logic        cpu_rst;
  logic        exe_i_div_start;
  logic        exe_i_div_signed;
  logic [31:0] exe_i_src1;
  logic [31:0] exe_i_src2;
  logic        exe_i_annul;
  logic        exe_o_stallreq;
  logic        exe_o_div_ready;
  logic [31:0] exe_o_div_hi;
  logic [31:0] exe_o_div_lo;

  int errors = 0;
  int checks = 0;

  exe_div dut (
    .cpu_clk_50M     (cpu_clk_50M),
    .cpu_rst         (cpu_rst),
    .exe_i_div_start (exe_i_div_start),
    .exe_i_div_signed(exe_i_div_signed),
    .exe_i_src1      (exe_i_src1),
    .exe_i_src2      (exe_i_src2),
    .exe_i_annul     (exe_i_annul),
    .exe_o_stallreq  (exe_o_stallreq),
    .exe_o_div_ready (exe_o_div_ready),
    .exe_o_div_hi    (exe_o_div_hi),
    .exe_o_div_lo    (exe_o_div_lo)
  );

  initial cpu_clk_50M = 1'b0;
  always #10 cpu_clk_50M = ~cpu_clk_50M;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 ns after the active edge; checks land one more ns later.
  task automatic step();
    @(posedge cpu_clk_50M);
    #2;
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi);
    exe_i_div_start  = 1'b1;
    exe_i_div_signed = sgn;
    exe_i_src1       = a;
    exe_i_src2       = b;
    #1;
    check({tag, " c0 stallreq"}, {31'd0, exe_o_stallreq}, 32'd1);
    check({tag, " c0 ready"}, {31'd0, exe_o_div_ready}, 32'd0);
    for (int c = 1; c <= 32; c++) begin
      step();
      #1;
      check({tag, " busy stallreq"}, {31'd0, exe_o_stallreq}, 32'd1);
      check({tag, " busy ready"}, {31'd0, exe_o_div_ready}, 32'd0);
    end
    step();
    #1;
    check({tag, " c33 ready"}, {31'd0, exe_o_div_ready}, 32'd1);
    check({tag, " c33 stallreq"}, {31'd0, exe_o_stallreq}, 32'd0);
    check({tag, " lo"}, exe_o_div_lo, exp_lo);
    check({tag, " hi"}, exe_o_div_hi, exp_hi);
    // Start is still high across the DONE edge; it must not be accepted there.
    step();
    exe_i_div_start = 1'b0;
  endtask

  initial begin
    cpu_rst          = 1'b1;
    exe_i_div_start  = 1'b0;
    exe_i_div_signed = 1'b0;
    exe_i_src1       = 32'd0;
    exe_i_src2       = 32'd0;
    exe_i_annul      = 1'b0;
    #5;
    check("reset hi", exe_o_div_hi, 32'd0);
    check("reset lo", exe_o_div_lo, 32'd0);
    check("reset ready", {31'd0, exe_o_div_ready}, 32'd0);
    check("reset stallreq", {31'd0, exe_o_stallreq}, 32'd0);
    step();
    cpu_rst = 1'b0;

    // Back-to-back divides: each starts in the cycle after the previous DONE.
    run_div("u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    run_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("s min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_div("u min/max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_div("s100/-7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2);
    run_div("umax/10", 1'b0, 32'hFFFF_FFFF, 32'd10, 32'h1999_9999, 32'd5);
    #1;
    check("b2b c34 ready", {31'd0, exe_o_div_ready}, 32'd0);

    // Divide by zero: three cycles in EXE.
    exe_i_div_start  = 1'b1;
    exe_i_div_signed = 1'b1;
    exe_i_src1       = 32'h1234_5678;
    exe_i_src2       = 32'd0;
    #1;
    check("dz c0 stallreq", {31'd0, exe_o_stallreq}, 32'd1);
    step();
    #1;
    check("dz c1 stallreq", {31'd0, exe_o_stallreq}, 32'd1);
    check("dz c1 ready", {31'd0, exe_o_div_ready}, 32'd0);
    step();
    #1;
    check("dz c2 ready", {31'd0, exe_o_div_ready}, 32'd1);
    check("dz c2 stallreq", {31'd0, exe_o_stallreq}, 32'd0);
    check("dz lo", exe_o_div_lo, 32'hFFFF_FFFF);
    check("dz hi", exe_o_div_hi, 32'h1234_5678);
    step();
    exe_i_div_start = 1'b0;
    #1;
    check("dz c3 ready", {31'd0, exe_o_div_ready}, 32'd0);

    // Annul in BUSY cycle 10.
    exe_i_div_start  = 1'b1;
    exe_i_div_signed = 1'b0;
    exe_i_src1       = 32'd1000;
    exe_i_src2       = 32'd3;
    for (int c = 1; c <= 10; c++) step();
    exe_i_annul = 1'b1;
    #1;
    check("annul c10 stallreq", {31'd0, exe_o_stallreq}, 32'd0);
    step();
    exe_i_annul     = 1'b0;
    exe_i_div_start = 1'b0;
    #1;
    check("annul c11 stallreq", {31'd0, exe_o_stallreq}, 32'd0);
    for (int c = 0; c < 30; c++) begin
      check("annul no ready", {31'd0, exe_o_div_ready}, 32'd0);
      step();
      #1;
    end
    check("annul keep lo", exe_o_div_lo, 32'hFFFF_FFFF);
    check("annul keep hi", exe_o_div_hi, 32'h1234_5678);

    // Asynchronous reset in BUSY cycle 5, start still held high.
    exe_i_div_start  = 1'b1;
    exe_i_div_signed = 1'b0;
    exe_i_src1       = 32'd100;
    exe_i_src2       = 32'd7;
    for (int c = 1; c <= 5; c++) step();
    #5;
    cpu_rst = 1'b1;
    #1;
    check("rst hi", exe_o_div_hi, 32'd0);
    check("rst lo", exe_o_div_lo, 32'd0);
    check("rst stallreq", {31'd0, exe_o_stallreq}, 32'd0);
    check("rst ready", {31'd0, exe_o_div_ready}, 32'd0);
    exe_i_div_start = 1'b0;
    step();
    cpu_rst = 1'b0;
    step();
    #1;
    check("post rst ready", {31'd0, exe_o_div_ready}, 32'd0);
    check("post rst stallreq", {31'd0, exe_o_stallreq}, 32'd0);
    run_div("rst u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    #1;
    check("final ready low", {31'd0, exe_o_div_ready}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
